// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, status flag positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    FN_NOP = 4'd0,
    FN_ADD = 4'd1,
    FN_SUB = 4'd2,
    FN_MUL = 4'd3,
    FN_AND = 4'd4,
    FN_OR  = 4'd5,
    FN_XOR = 4'd6,
    FN_SHL = 4'd7,
    FN_SHR = 4'd8,
    FN_DIV = 4'd9,
    FN_MOD = 4'd10
  } func_e;

  localparam int FLAG_EQU    = 0;
  localparam int FLAG_NEQU   = 1;
  localparam int FLAG_BTHAN  = 2;
  localparam int FLAG_BEQUAL = 3;
  localparam int FLAG_LTHAN  = 4;
  localparam int FLAG_LEQUAL = 5;
  localparam int FLAG_CARRY  = 6;
  localparam int FLAG_ERR    = 7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier, plus a restoring divider when ALU_DIV_EN is defined.
// Runs WIDTH steps after start; done is high during the last step, result is the post-step value.
module alu_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef ALU_DIV_EN
  input  logic               div_sel,
`endif
  input  logic [WIDTH-1:0]   t,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               busy;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;
`ifdef ALU_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     diff;
`endif

  // acc = {partial product, remaining multiplier} or {remainder, quotient/dividend}.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (div_q) begin
      acc_nxt = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  assign done   = busy && (count == CW'(WIDTH - 1));
  assign result = acc_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
    end else if (busy) begin
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  // NOTE: datapath registers are left unreset; start always reloads them before they matter.
  always_ff @(posedge clk) begin
    if (start) begin
`ifdef ALU_DIV_EN
      div_q <= div_sel;
      acc   <= {{WIDTH{1'b0}}, div_sel ? t : b};
      opnd  <= div_sel ? b : t;
`else
      acc   <= {{WIDTH{1'b0}}, b};
      opnd  <= t;
`endif
    end else if (busy) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with status flags; iterative MUL (MUL_ITER) and optional DIV/MOD.
// Optional feature macro: ALU_DIV_EN enables funcs DIV/MOD through the restoring divider.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MUL_ITER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic             imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm_val,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       status_reg
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state, state_nxt;
  func_e              func_in, func_q, op_f;
  logic [WIDTH-1:0]   t_in, t_q, b_q, op_t, op_b;
  logic [WIDTH-1:0]   res;
  logic [WIDTH:0]     sum_w;
  logic [2*WIDTH-1:0] shl_w, mul_full, iter_res;
  logic               carry, err, equ, bthan, lthan;
  logic               accept, is_iter, iter_start, iter_done, load_result;
  logic [7:0]         flags;

  assign func_in  = func_e'(func);
  assign t_in     = imm ? imm_val : a;
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    is_iter = (func_in == FN_MUL) && (MUL_ITER != 0);
`ifdef ALU_DIV_EN
    if (func_in == FN_DIV || func_in == FN_MOD) is_iter = 1'b1;
`endif
  end

  assign iter_start = accept && is_iter;

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
`ifdef ALU_DIV_EN
    .div_sel(func_in != FN_MUL),
`endif
    .t      (t_in),
    .b      (b),
    .done   (iter_done),
    .result (iter_res)
  );

  // Single-cycle ops evaluate live inputs at accept; iterative ops finish on the captured ones.
  assign op_t     = in_ready ? t_in : t_q;
  assign op_b     = in_ready ? b : b_q;
  assign op_f     = in_ready ? func_in : func_q;
  assign mul_full = {{WIDTH{1'b0}}, op_t} * {{WIDTH{1'b0}}, op_b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    err   = 1'b0;
    sum_w = '0;
    shl_w = '0;
    case (op_f)
      FN_NOP: res = op_t;
      FN_ADD: begin
        sum_w = {1'b0, op_t} + {1'b0, op_b};
        res   = sum_w[WIDTH-1:0];
        carry = sum_w[WIDTH];
      end
      FN_SUB: begin
        sum_w = {1'b0, op_t} - {1'b0, op_b};
        res   = sum_w[WIDTH-1:0];
        carry = sum_w[WIDTH];
      end
      FN_MUL: begin
        if (MUL_ITER != 0) begin
          res   = iter_res[WIDTH-1:0];
          carry = |iter_res[2*WIDTH-1:WIDTH];
        end else begin
          res   = mul_full[WIDTH-1:0];
          carry = |mul_full[2*WIDTH-1:WIDTH];
        end
      end
      FN_AND: res = op_t & op_b;
      FN_OR:  res = op_t | op_b;
      FN_XOR: res = op_t ^ op_b;
      FN_SHL: begin
        shl_w = {{WIDTH{1'b0}}, op_t} << op_b[SHW-1:0];
        res   = shl_w[WIDTH-1:0];
        carry = |shl_w[2*WIDTH-1:WIDTH];
      end
      FN_SHR: res = op_t >> op_b[SHW-1:0];
`ifdef ALU_DIV_EN
      FN_DIV: begin
        res = iter_res[WIDTH-1:0];
        err = (op_b == '0);
      end
      FN_MOD: begin
        res = iter_res[2*WIDTH-1:WIDTH];
        err = (op_b == '0);
      end
`endif
      default: err = 1'b1;
    endcase

    equ   = (res == '0);
    bthan = (op_t > op_b);
    lthan = (op_t < op_b);
    flags = '0;
    flags[FLAG_EQU]    = equ;
    flags[FLAG_NEQU]   = ~equ;
    flags[FLAG_BTHAN]  = bthan;
    flags[FLAG_BEQUAL] = bthan | equ;
    flags[FLAG_LTHAN]  = lthan;
    flags[FLAG_LEQUAL] = lthan | equ;
    flags[FLAG_CARRY]  = carry;
    flags[FLAG_ERR]    = err;
  end

  always_comb begin
    state_nxt   = state;
    load_result = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        state_nxt   = is_iter ? BUSY : DONE;
        load_result = !is_iter;
      end
      BUSY: if (iter_done) begin
        state_nxt   = DONE;
        load_result = 1'b1;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out        <= '0;
      status_reg <= '0;
    end else begin
      state <= state_nxt;
      if (load_result) begin
        out        <= res;
        status_reg <= flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      t_q    <= t_in;
      b_q    <= b;
      func_q <= func_in;
    end
  end

endmodule
